// File: rtl/iter_shift.sv
// iter_shift: iterative logical shifter.
//   A start request in IDLE captures din, shamt and dir. The operand is then
//   shifted a few positions per clock until the requested amount is reached.
//   Each SHIFT cycle moves 5 positions while at least 5 remain, otherwise 1.
//   An amount of s therefore takes floor(s/5) + (s mod 5) cycles.
//
// Ports
//   clk       : single clock, rising edge
//   reset     : synchronous, active-high; returns to IDLE and clears the result
//   start     : request pulse, looked at only in IDLE
//   din       : operand (n bits), captured on an accepted start
//   shamt     : shift amount 0..31, captured on an accepted start
//   dir       : 0 = logical left, 1 = logical right, captured on an accepted start
//   dout      : working/result register
//   busy      : high while in SHIFT
//   done      : one-cycle pulse, high while in DONE
//   state_dbg : current FSM state (0 = IDLE, 1 = SHIFT, 2 = DONE), for debug
//
// Handshake: start is a request with no ready. It is accepted on any rising
// edge where the block is in IDLE and reset is low. At any other time it is
// ignored. Completion is signalled by exactly one done cycle. When shamt == 0,
// done is signalled without any busy cycle.
module iter_shift #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] din,
  input  logic [4:0]   shamt,
  input  logic         dir,
  output logic [n-1:0] dout,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [n-1:0] work, work_next;
  logic [4:0]   rem, rem_next;
  logic         dir_q, dir_next;
  logic [4:0]   step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      work  <= '0;
      rem   <= '0;
      dir_q <= 1'b0;
    end else begin
      state <= state_next;
      work  <= work_next;
      rem   <= rem_next;
      dir_q <= dir_next;
    end
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    rem_next   = rem;
    dir_next   = dir_q;
    // Coarse steps of 5 while they fit, then single steps for the remainder.
    step       = (rem >= 5'd5) ? 5'd5 : 5'd1;
    case (state)
      IDLE: begin
        if (start) begin
          work_next  = din;
          rem_next   = shamt;
          dir_next   = dir;
          state_next = (shamt != 5'd0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_next = dir_q ? (work >> step) : (work << step);
        rem_next  = rem - step;
        // rem is never 0 in SHIFT, so this step is the last one exactly when
        // it consumes the whole remaining count.
        if (rem == step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dout      = work;
  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_iter_shift.sv
// Testbench for iter_shift (n = 32).
// Expected results come from plain arithmetic on the captured operands:
// the result is din << s or din >> s, and the cycle count is s/5 + s%5.
module tb_iter_shift;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] din;
  logic [4:0]  shamt;
  logic        dir;
  logic [31:0] dout;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  int total;
  int bad;

  iter_shift #(.n(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .shamt     (shamt),
    .dir       (dir),
    .dout      (dout),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and check its timing and result.
  // When restart is set, start is pulsed again with fresh operands during
  // every busy cycle. The first operation's result must not change.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic dr,
                        input bit restart, input string tag);
    logic [31:0] exp_v;
    int          exp_m;
    int          edges;
    int          busy_cnt;
    bit          seen_done;
    bit          overlap;
    exp_v = dr ? (d >> s) : (d << s);
    exp_m = int'(s) / 5 + int'(s) % 5;
    @(negedge clk);
    din   = d;
    shamt = s;
    dir   = dr;
    start = 1'b1;
    @(posedge clk);  // edge k: operation accepted
    #1;
    start     = 1'b0;
    din       = $urandom;
    shamt     = 5'($urandom_range(31, 0));
    dir       = 1'($urandom_range(1, 0));
    edges     = 0;
    busy_cnt  = 0;
    seen_done = 0;
    overlap   = 0;
    while (!seen_done && edges < 20) begin
      if (busy && done) overlap = 1;
      if (busy) busy_cnt++;
      if (done) begin
        seen_done = 1;
      end else begin
        start = (restart && busy) ? 1'b1 : 1'b0;
        if (restart) begin
          din   = $urandom;
          shamt = 5'($urandom_range(31, 1));
          dir   = ~dr;
        end
        @(posedge clk);
        #1;
        edges++;
      end
    end
    start = 1'b0;
    chk({tag, " done_seen"}, 64'(seen_done), 64'd1);
    chk({tag, " done_edge"}, 64'(edges), 64'(exp_m));
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_m));
    chk({tag, " busy_done_overlap"}, 64'(overlap), 64'd0);
    chk({tag, " dout"}, 64'(dout), 64'(exp_v));
    // done is a single pulse, then the result holds while idle.
    @(posedge clk);
    #1;
    chk({tag, " done_single"}, 64'(done), 64'd0);
    chk({tag, " idle_state"}, 64'(state_dbg), 64'd0);
    din = ~d;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " dout_hold"}, 64'(dout), 64'(exp_v));
  endtask

  initial begin
    int guard;
    bit done_after_abort;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    shamt = '0;
    dir   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset dout", 64'(dout), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases.
    run_op(32'h0000_0001, 5'd5,  1'b0, 0, "d_s5_left");
    run_op(32'h0000_0001, 5'd31, 1'b0, 0, "d_s31_left");
    run_op(32'h8000_0000, 5'd7,  1'b1, 0, "d_s7_right");
    run_op(32'hFFFF_FFFF, 5'd4,  1'b0, 0, "d_s4_left");
    run_op(32'hDEAD_BEEF, 5'd0,  1'b0, 0, "d_s0");
    run_op(32'h1234_5678, 5'd13, 1'b1, 1, "d_restart_ignored");

    // Reset in the third SHIFT cycle of a shamt=31 operation.
    @(negedge clk);
    din   = 32'h0000_0001;
    shamt = 5'd31;
    dir   = 1'b0;
    start = 1'b1;
    @(posedge clk);  // edge k
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);  // now in third SHIFT cycle
    #1;
    chk("abort busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort state", 64'(state_dbg), 64'd0);
    chk("abort dout", 64'(dout), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    done_after_abort = 0;
    for (guard = 0; guard < 10; guard++) begin
      if (done || busy) done_after_abort = 1;
      @(posedge clk);
      #1;
    end
    chk("abort no_done", 64'(done_after_abort), 64'd0);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    din   = 32'hCAFE_F00D;
    shamt = 5'd9;
    @(posedge clk);
    #1;
    chk("prio state", 64'(state_dbg), 64'd0);
    chk("prio dout", 64'(dout), 64'd0);
    chk("prio busy", 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // First start after reset is accepted immediately.
    run_op(32'hCAFE_F00D, 5'd9, 1'b0, 0, "post_reset");

    // Random sweep: every shift amount in both directions.
    for (int s = 0; s < 32; s++) begin
      for (int dr = 0; dr < 2; dr++) begin
        run_op($urandom, 5'(s), 1'(dr), 0, $sformatf("rnd_s%0d_d%0d", s, dr));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
